// File: rtl/word_uart_tx_pkg.sv
// Shared types and constants for the 32-bit word UART transmitter.
// The PARITY state is only reached when WORD_UART_TX_PARITY_EN is defined.
package word_uart_pkg;

   localparam int UART_DATA_BITS       = 8;
   localparam int DEFAULT_CLKS_PER_BIT = 434;
   localparam int WORD_W               = 32;
   localparam int WORD_BYTES_DEF       = WORD_W / UART_DATA_BITS;
   localparam int BYTE_IDX_W           = $clog2(WORD_BYTES_DEF);
   localparam int BIT_CNT_W            = $clog2(UART_DATA_BITS);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      PARITY
   } tx_state_e;

   // Byte idx of a word, byte 0 being the least significant.
   function automatic logic [UART_DATA_BITS-1:0] byte_sel(
      input logic [WORD_W-1:0]     w,
      input logic [BYTE_IDX_W-1:0] idx
   );
      return w[idx*UART_DATA_BITS +: UART_DATA_BITS];
   endfunction

endpackage

// File: rtl/word_uart_tx_if.sv
// Valid/ready word handshake between the result datapath and the UART transmitter.
interface word_uart_tx_if;
   import word_uart_pkg::*;

   logic [WORD_W-1:0] word_in;
   logic              word_valid;
   logic              word_ready;

   modport master (
      output word_in,
      output word_valid,
      input  word_ready
   );

   modport slave (
      input  word_in,
      input  word_valid,
      output word_ready
   );

endinterface

// File: rtl/word_uart_tx_baud_tick.sv
// Bit-period counter: counts CLKS_PER_BIT enabled cycles and flags the last one.
module uart_baud_tick #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic clk,
   input  logic clr_n,
   input  logic clr_i,
   input  logic en_i,
   output logic tick_o
);

   localparam int               CNT_W   = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // The bit advances on the same edge that wraps the counter.
   assign tick_o = en_i && !clr_i && (cnt_q == CNT_MAX);

endmodule

// File: rtl/word_uart_tx.sv
// Latches a 32-bit word and sends it as four back-to-back UART frames, LSB byte first.
// Define WORD_UART_TX_PARITY_EN for 8E1 frames; the default build sends 8N1.
module word_uart_tx
   import word_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int WORD_BYTES   = WORD_BYTES_DEF
) (
   input  logic          clk,
   input  logic          clr_n,
   word_uart_tx_if.slave bus,
   output logic          tx,
   output logic          busy
);

   localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(WORD_BYTES - 1);
   localparam logic [BIT_CNT_W-1:0]  LAST_BIT  = BIT_CNT_W'(UART_DATA_BITS - 1);

   tx_state_e                 state_q;
   logic [WORD_W-1:0]         hold_q;
   logic [UART_DATA_BITS-1:0] shift_q;
   logic [BIT_CNT_W-1:0]      bit_cnt_q;
   logic [BYTE_IDX_W-1:0]     byte_idx_q;
   logic                      tx_q;
   logic                      busy_q;
   logic                      ready_q;

   logic                      accept;
   logic                      bit_tick;
   logic                      tx_d;
   logic [BYTE_IDX_W-1:0]     byte_idx_d;

   assign accept     = ready_q && bus.word_valid;
   assign byte_idx_d = byte_idx_q + BYTE_IDX_W'(1);

   uart_baud_tick #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clk    (clk),
      .clr_n  (clr_n),
      .clr_i  (accept),
      .en_i   (busy_q),
      .tick_o (bit_tick)
   );

   // Line level for the current state; registered so tx trails the state by one cycle.
   always_comb begin
      tx_d = 1'b1;
      case (state_q)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_q[0];
`ifdef WORD_UART_TX_PARITY_EN
         PARITY:  tx_d = ^byte_sel(hold_q, byte_idx_q);
`endif
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q    <= IDLE;
         hold_q     <= '0;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         byte_idx_q <= '0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         ready_q    <= 1'b1;
      end else begin
         tx_q <= tx_d;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  hold_q     <= bus.word_in;
                  shift_q    <= bus.word_in[UART_DATA_BITS-1:0];
                  byte_idx_q <= '0;
                  bit_cnt_q  <= '0;
                  busy_q     <= 1'b1;
                  ready_q    <= 1'b0;
                  state_q    <= START;
               end
            end
            START: begin
               if (bit_tick) begin
                  state_q <= DATA;
               end
            end
            DATA: begin
               if (bit_tick) begin
                  shift_q   <= shift_q >> 1;
                  bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
                  if (bit_cnt_q == LAST_BIT) begin
`ifdef WORD_UART_TX_PARITY_EN
                     state_q <= PARITY;
`else
                     state_q <= STOP;
`endif
                  end
               end
            end
`ifdef WORD_UART_TX_PARITY_EN
            PARITY: begin
               if (bit_tick) begin
                  state_q <= STOP;
               end
            end
`endif
            STOP: begin
               if (bit_tick) begin
                  if (byte_idx_q != LAST_BYTE) begin
                     // Next start bit follows the stop bit with no idle gap.
                     byte_idx_q <= byte_idx_d;
                     shift_q    <= byte_sel(hold_q, byte_idx_d);
                     state_q    <= START;
                  end else begin
                     busy_q  <= 1'b0;
                     ready_q <= 1'b1;
                     state_q <= IDLE;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign tx             = tx_q;
   assign busy           = busy_q;
   assign bus.word_ready = ready_q;

endmodule
